// File: rtl/powlib_burstpack_if.sv
// Handshake bundle for powlib_burstpack: FIFO-side input stream, flush request and framed output stream.
interface powlib_burstpack_if #(
    parameter int W = 16,
    parameter int B = 8
);
    localparam int WB = $clog2(B + 1);

    logic [W-1:0]  indata;
    logic          invld;
    logic          inrdy;
    logic          flush;
    logic [W-1:0]  outdata;
    logic          outvld;
    logic          outrdy;
    logic          outlast;
    logic [WB-1:0] outidx;

    modport slave (
        input  indata, invld, flush, outrdy,
        output inrdy, outdata, outvld, outlast, outidx
    );

    modport master (
        output indata, invld, flush, outrdy,
        input  inrdy, outdata, outvld, outlast, outidx
    );
endinterface

// File: rtl/powlib_burstpack.sv
// Burst framer behind a powlib FIFO read port: tags words with 1-based burst position and end-of-burst.
// Define POWLIB_BURSTPACK_CNT_EN to add the 16-bit completed-burst counter output bcnt.
module powlib_burstpack #(
    parameter int W  = 16,
    parameter int B  = 8,
    parameter int TO = 16
) (
    input  logic clk,
    input  logic rst,
    powlib_burstpack_if.slave bus
`ifdef POWLIB_BURSTPACK_CNT_EN
    ,
    output logic [15:0] bcnt
`endif
);
    localparam int WB = $clog2(B + 1);
    localparam int TW = $clog2(TO) + 1;

    logic [W-1:0]  hdata;
    logic [WB-1:0] hidx;
    logic          hvld;
    logic [TW-1:0] tcnt;

    logic [W-1:0]  outdata_q;
    logic [WB-1:0] outidx_q;
    logic          outlast_q;
    logic          outvld_q;

    logic ofree, inrdy, acc, tmo, hfull, last, mv;

    // The held word's last flag is only known once its successor arrives, the burst fills, it times out or a flush comes.
    assign ofree = ~outvld_q | bus.outrdy;
    assign inrdy = ~hvld | ofree;
    assign acc   = bus.invld & inrdy;
    assign tmo   = hvld & ~acc & (tcnt == TW'(TO - 1));
    assign hfull = (hidx == WB'(B));
    assign last  = hfull | tmo | bus.flush;
    assign mv    = hvld & ofree & (acc | last);

    assign bus.inrdy   = inrdy;
    assign bus.outdata = outdata_q;
    assign bus.outidx  = outidx_q;
    assign bus.outlast = outlast_q;
    assign bus.outvld  = outvld_q;

    // Hold stage: a new word restarts numbering when the word leaving alongside it closed its burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdata <= '0;
            hidx  <= '0;
            hvld  <= 1'b0;
        end else if (acc) begin
            hdata <= bus.indata;
            hidx  <= (hvld & ~(mv & last)) ? hidx + WB'(1) : WB'(1);
            hvld  <= 1'b1;
        end else if (mv) begin
            hvld  <= 1'b0;
        end
    end

    // Idle counter saturates so a timed-out word stays releasable while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (acc) begin
            tcnt <= '0;
        end else if (hvld && (tcnt != TW'(TO - 1))) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outdata_q <= '0;
            outidx_q  <= '0;
            outlast_q <= 1'b0;
            outvld_q  <= 1'b0;
        end else if (mv) begin
            outdata_q <= hdata;
            outidx_q  <= hidx;
            outlast_q <= last;
            outvld_q  <= 1'b1;
        end else if (outvld_q && bus.outrdy) begin
            outvld_q  <= 1'b0;
        end
    end

`ifdef POWLIB_BURSTPACK_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
        end else if (outvld_q && bus.outrdy && outlast_q) begin
            bcnt <= bcnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_powlib_burstpack.sv
// Self-checking bench for powlib_burstpack: directed scenarios plus randomized traffic against a burst-level model.
module tb_powlib_burstpack;
    localparam int W  = 16;
    localparam int B  = 4;
    localparam int TO = 3;

    typedef struct {
        logic [15:0] d;
        int          idx;
        bit          last;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        int          idx;
        bit          last;
        int          cyc;
    } got_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    powlib_burstpack_if #(.W(W), .B(B)) bus ();

`ifdef POWLIB_BURSTPACK_CNT_EN
    logic [15:0] bcnt;
`endif

    powlib_burstpack #(.W(W), .B(B), .TO(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef POWLIB_BURSTPACK_CNT_EN
        ,
        .bcnt(bcnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: the word still waiting for its end-of-burst verdict, its burst position and idle age.
    bit          m_pv;
    logic [15:0] m_pd;
    int          m_pos;
    int          m_age;
    bit          m_slot;
    logic [15:0] m_bursts;
    exp_t        exp_q[$];
    got_t        got_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    task automatic modelReset();
        m_pv     = 1'b0;
        m_pd     = '0;
        m_pos    = 0;
        m_age    = 0;
        m_slot   = 1'b0;
        m_bursts = '0;
        exp_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        bus.invld  = 1'b0;
        bus.indata = '0;
        bus.flush  = 1'b0;
        bus.outrdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus; the model predicts readiness and which words leave the hold slot, and with what tags.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic f, input logic r);
        bit   ofree, rdy, acc, ends, rel;
        exp_t e;
        got_t g;
        @(negedge clk);
        bus.invld  = v;
        bus.indata = d;
        bus.flush  = f;
        bus.outrdy = r;
        #1;
        ofree = !m_slot || r;
        rdy   = !m_pv || ofree;
        checkOutput("inrdy", 32'(bus.inrdy), 32'(rdy));
        checkOutput("outvld", 32'(bus.outvld), 32'(m_slot));
        if (bus.outvld && r) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_word", 32'(bus.outdata), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("outdata", 32'(bus.outdata), 32'(e.d));
                checkOutput("outidx", 32'(bus.outidx), 32'(e.idx));
                checkOutput("outlast", 32'(bus.outlast), 32'(e.last));
                if (e.last) m_bursts = m_bursts + 16'd1;
            end
            g.d    = bus.outdata;
            g.idx  = int'(bus.outidx);
            g.last = bus.outlast;
            g.cyc  = cyc;
            got_q.push_back(g);
        end
        acc  = v && rdy;
        ends = m_pv && ((m_pos == B) || f || (!acc && m_age >= TO - 1));
        rel  = m_pv && ofree && (acc || ends);
        if (rel) begin
            e.d = m_pd; e.idx = m_pos; e.last = ends;
            exp_q.push_back(e);
            m_slot = 1'b1;
        end else if (r) begin
            m_slot = 1'b0;
        end
        if (acc) begin
            m_pos = (m_pv && !(rel && ends)) ? m_pos + 1 : 1;
            m_pd  = d;
            m_pv  = 1'b1;
            m_age = 0;
        end else if (rel) begin
            m_pv = 1'b0;
        end else if (m_pv) begin
            m_age++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic runStream10(output int s);
        got_q.delete();
        s = cyc;
        for (int j = 1; j <= 10; j++) begin
            applyStimulus(1'b1, 16'(j), 1'b0, 1'b1);
            checkOutput("s1_inrdy", 32'(bus.inrdy), 32'd1);
        end
        idle(6);
    endtask

    initial begin
        int  s;
        bit  seen;
        bit  lst;
        bus.invld  = 1'b0;
        bus.indata = '0;
        bus.flush  = 1'b0;
        bus.outrdy = 1'b1;
        modelReset();

        doReset();
        #1;
        checkOutput("rst_outvld", 32'(bus.outvld), 32'd0);
        checkOutput("rst_outdata", 32'(bus.outdata), 32'd0);
        checkOutput("rst_outidx", 32'(bus.outidx), 32'd0);
        checkOutput("rst_outlast", 32'(bus.outlast), 32'd0);
        checkOutput("rst_inrdy", 32'(bus.inrdy), 32'd1);

        // Back-to-back stream: bursts of four, final partial burst closed by the idle timeout.
        runStream10(s);
        checkOutput("s1_count", 32'(got_q.size()), 32'd10);
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            lst = (k == 3) || (k == 7) || (k == 9);
            checkOutput("s1_data", 32'(got_q[k].d), 32'(k + 1));
            checkOutput("s1_idx", 32'(got_q[k].idx), 32'((k % 4) + 1));
            checkOutput("s1_last", 32'(got_q[k].last), 32'(lst));
            checkOutput("s1_cyc", 32'(got_q[k].cyc - s), 32'((k < 9) ? k + 2 : 13));
        end

        // Lone word: emitted three cycles after acceptance as a one-word burst.
        doReset();
        got_q.delete();
        s = cyc;
        applyStimulus(1'b1, 16'hABCD, 1'b0, 1'b1);
        idle(7);
        checkOutput("s2_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            checkOutput("s2_data", 32'(got_q[0].d), 32'hABCD);
            checkOutput("s2_idx", 32'(got_q[0].idx), 32'd1);
            checkOutput("s2_last", 32'(got_q[0].last), 32'd1);
            checkOutput("s2_cyc", 32'(got_q[0].cyc - s), 32'd4);
        end

        // Backpressure: two words absorbed, third refused, presented word held stable.
        doReset();
        got_q.delete();
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        checkOutput("s3_rdy0", 32'(bus.inrdy), 32'd1);
        applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0);
        checkOutput("s3_rdy1", 32'(bus.inrdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0033, 1'b0, 1'b0);
            checkOutput("s3_stall_rdy", 32'(bus.inrdy), 32'd0);
            checkOutput("s3_stall_data", 32'(bus.outdata), 32'h0011);
            checkOutput("s3_stall_idx", 32'(bus.outidx), 32'd1);
        end
        applyStimulus(1'b1, 16'h0033, 1'b0, 1'b1);
        idle(8);
        checkOutput("s3_count", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            checkOutput("s3_data", 32'(got_q[k].d), 32'((k + 1) * 16'h0011));
            checkOutput("s3_idx", 32'(got_q[k].idx), 32'(k + 1));
            checkOutput("s3_last", 32'(got_q[k].last), 32'(k == 2));
        end

        // Flush held until the closing word is seen, then a fresh burst starts at index 1.
        doReset();
        got_q.delete();
        applyStimulus(1'b1, 16'h0101, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0202, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
            if (got_q.size() > 0 && got_q[got_q.size() - 1].last) seen = 1'b1;
        end
        checkOutput("s4_flush_seen", 32'(seen), 32'd1);
        applyStimulus(1'b1, 16'h0303, 1'b0, 1'b1);
        idle(6);
        checkOutput("s4_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            checkOutput("s4_data1", 32'(got_q[1].d), 32'h0202);
            checkOutput("s4_idx1", 32'(got_q[1].idx), 32'd2);
            checkOutput("s4_last1", 32'(got_q[1].last), 32'd1);
            checkOutput("s4_data2", 32'(got_q[2].d), 32'h0303);
            checkOutput("s4_idx2", 32'(got_q[2].idx), 32'd1);
        end

        // Asynchronous reset with both stages occupied.
        doReset();
        got_q.delete();
        applyStimulus(1'b1, 16'h0A01, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0A02, 1'b0, 1'b0);
        @(negedge clk);
        bus.invld = 1'b0;
        #1;
        checkOutput("s5_full_vld", 32'(bus.outvld), 32'd1);
        checkOutput("s5_full_rdy", 32'(bus.inrdy), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("s5_async_vld", 32'(bus.outvld), 32'd0);
        checkOutput("s5_async_rdy", 32'(bus.inrdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b1);
        idle(6);
        checkOutput("s5_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            checkOutput("s5_data", 32'(got_q[0].d), 32'h0AAA);
            checkOutput("s5_idx", 32'(got_q[0].idx), 32'd1);
        end

        // Randomized traffic with random flushes and output stalls.
        doReset();
        got_q.delete();
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
        end
        idle(20);
        checkOutput("rand_drain", 32'(exp_q.size()), 32'd0);

`ifdef POWLIB_BURSTPACK_CNT_EN
        doReset();
        #1;
        checkOutput("cnt_rst", 32'(bcnt), 32'd0);
        runStream10(s);
        checkOutput("cnt_three", 32'(bcnt), 32'd3);
        doReset();
        got_q.delete();
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b1);
            if (got_q.size() > 8) void'(got_q.pop_front());
        end
        idle(8);
        checkOutput("cnt_model_wrap", 32'(m_bursts), 32'd0);
        checkOutput("cnt_wrap", 32'(bcnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
